// File: rtl/dmem_bus_master_pkg.sv
// Shared encodings for the data-memory bus master: bus size codes, FSM states
// and the memory-mapped console / exit addresses.
package dmem_bus_master_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

    localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'hFF00_0000;

    // Natural alignment check; the reserved size code is never legal.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_WORD: ok = (addr_lo == 2'b00);
            SZ_HALF: ok = ~addr_lo[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Lane formatting shared by both directions: right-justified store data is
// masked to the access size, and load data is zero- or sign-extended.
module dmem_lane_fmt
    import dmem_bus_master_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [1:0]           size_i,
    input  logic                 signed_i,
    input  logic [BIT_WIDTH-1:0] load_raw_i,
    input  logic [BIT_WIDTH-1:0] store_raw_i,
    output logic [BIT_WIDTH-1:0] load_ext_o,
    output logic [BIT_WIDTH-1:0] store_fmt_o
);

    always_comb begin
        load_ext_o  = load_raw_i;
        store_fmt_o = store_raw_i;
        case (size_i)
            SZ_HALF: begin
                load_ext_o  = {{(BIT_WIDTH-16){signed_i & load_raw_i[15]}}, load_raw_i[15:0]};
                store_fmt_o = {{(BIT_WIDTH-16){1'b0}}, store_raw_i[15:0]};
            end
            SZ_BYTE: begin
                load_ext_o  = {{(BIT_WIDTH-8){signed_i & load_raw_i[7]}}, load_raw_i[7:0]};
                store_fmt_o = {{(BIT_WIDTH-8){1'b0}}, store_raw_i[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bus_master.sv
// Load/store bus master: converts pipeline requests into single bus cycles on
// DAD/DDT with an active-low acknowledge and a bounded wait.
module dmem_bus_master
    import dmem_bus_master_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    input  logic                 ACKD_n
);

    localparam int              CNT_W    = 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] dad_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [BIT_WIDTH-1:0] rdata_q;
    logic [1:0]           size_q;
    logic                 write_q;
    logic                 signed_q;
    logic                 mreq_q;
    logic                 resp_valid_q;
    logic                 resp_err_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 accept;
    logic                 legal;
    logic                 ack_hit;
    logic                 tmo_hit;
    logic                 drive_en;
    logic [BIT_WIDTH-1:0] load_ext;
    logic [BIT_WIDTH-1:0] store_fmt;

    dmem_lane_fmt #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_lane_fmt (
        .size_i      (size_q),
        .signed_i    (signed_q),
        .load_raw_i  (DDT),
        .store_raw_i (wdata_q),
        .load_ext_o  (load_ext),
        .store_fmt_o (store_fmt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Acknowledge outranks the timeout when both land on the same edge.
    always_comb begin
        accept  = req_valid && (state_q == ST_IDLE);
        legal   = req_legal(req_size, req_addr[1:0]);
        ack_hit = (state_q == ST_BUS) && !ACKD_n;
        tmo_hit = (state_q == ST_BUS) && ACKD_n && (cnt_q == TMO_LAST);
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && legal)    state_d = ST_BUS;
            ST_BUS:  if (ack_hit || tmo_hit) state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        drive_en   = (state_q == ST_BUS) && write_q;
        resp_valid = resp_valid_q;
        resp_err   = resp_err_q;
        resp_rdata = rdata_q;
        DAD        = dad_q;
        MREQ       = mreq_q;
        WRITE      = write_q;
        SIZE       = size_q;
    end

    assign DDT = drive_en ? store_fmt : {BIT_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dad_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            size_q       <= SZ_WORD;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            mreq_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            if (accept) begin
                if (legal) begin
                    dad_q    <= req_addr;
                    wdata_q  <= req_wdata;
                    size_q   <= req_size;
                    write_q  <= req_write;
                    signed_q <= req_signed;
                    mreq_q   <= 1'b1;
                    cnt_q    <= '0;
                end else begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    rdata_q      <= '0;
                end
            end else if (state_q == ST_BUS) begin
                if (ack_hit) begin
                    mreq_q       <= 1'b0;
                    resp_valid_q <= 1'b1;
                    rdata_q      <= write_q ? '0 : load_ext;
                end else if (tmo_hit) begin
                    mreq_q       <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    rdata_q      <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_master.sv
// Bench for dmem_bus_master: a vector table run back-to-back through a memory
// responder, plus stale-acknowledge and mid-transaction reset sequences.
module tb_dmem_bus_master;
    import dmem_bus_master_pkg::*;

    localparam int TMO = 4;

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          dly;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] ddt;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          mq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, dad;
    logic        mreq, write_o;
    logic [1:0]  size_o;
    wire  [31:0] ddt;
    logic        ackd_n;

    logic        mem_oe    = 1'b0;
    logic [31:0] mem_drv   = '0;
    logic [31:0] mem_data  = '0;
    int          mem_dly   = 0;
    int          mreq_cnt  = 0;
    bit          stale_ack = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[15];
    vec_t vpost;

    assign ddt = mem_oe ? mem_drv : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    dmem_bus_master #(
        .BIT_WIDTH (32),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .DAD        (dad),
        .MREQ       (mreq),
        .WRITE      (write_o),
        .SIZE       (size_o),
        .DDT        (ddt),
        .ACKD_n     (ackd_n)
    );

    // Memory model: acks mem_dly cycles into MREQ (negative = never acks).
    initial begin
        ackd_n = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (mreq) begin
                if (mem_dly >= 0 && mreq_cnt >= mem_dly) begin
                    ackd_n = 1'b0;
                    if (!write_o) begin
                        mem_oe  = 1'b1;
                        mem_drv = mem_data;
                    end
                end else begin
                    ackd_n = 1'b1;
                end
                mreq_cnt++;
            end else begin
                mreq_cnt = 0;
                ackd_n   = !stale_ack;
                mem_oe   = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_rel(input string name, input logic [31:0] v);
        bit bad = 1'b0;
        checks++;
        for (int i = 0; i < 32; i++) if (v[i] === 1'b1) bad = 1'b1;
        if (bad) begin
            errors++;
            $display("FAIL %s got %h want released bus", name, v);
        end
    endtask

    task automatic issue(input vec_t v, input string tag);
        exp_t e;
        chk({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        mem_dly    = v.dly;
        mem_data   = v.mem;
        e.rdata    = v.rdata;
        e.err      = v.err;
        if (v.dly < 0) begin
            e.lat = TMO + 1;
            e.mq  = TMO;
        end else if (v.err) begin
            e.lat = 1;
            e.mq  = 0;
        end else begin
            e.lat = v.dly + 2;
            e.mq  = v.dly + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic complete(input vec_t v, input string tag);
        int   n    = 0;
        int   mq   = 0;
        bit   seen = 1'b0;
        exp_t e;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (mreq) begin
                mq++;
                if (mq == 1) begin
                    chk({tag, " DAD"}, dad, v.addr);
                    chk({tag, " SIZE"}, {30'b0, size_o}, {30'b0, v.size});
                    chk({tag, " WRITE"}, {31'b0, write_o}, {31'b0, v.wr});
                    if (v.wr) chk({tag, " DDT"}, ddt, v.ddt);
                end
            end
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s resp_valid got none within %0d cycles want pulse", tag, n);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard got response want empty queue", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " rdata"}, resp_rdata, e.rdata);
            chk({tag, " err"}, {31'b0, resp_err}, {31'b0, e.err});
            chk({tag, " latency"}, 32'(n), 32'(e.lat));
            chk({tag, " mreq_cycles"}, 32'(mq), 32'(e.mq));
            chk_rel({tag, " DDT after"}, ddt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr    size     sgn   addr           wdata          mem            dly err   rdata          ddt
        vecs[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h0800_0010, 32'h0,         32'hDEAD_BEEF, 0,  1'b0, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0800_0003, 32'h0,         32'h1234_5680, 0,  1'b0, 32'hFFFF_FF80, 32'h0};
        vecs[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0800_0003, 32'h0,         32'h1234_5680, 0,  1'b0, 32'h0000_0080, 32'h0};
        vecs[3]  = '{1'b0, SZ_HALF, 1'b1, 32'h0800_0002, 32'h0,         32'hABCD_8001, 0,  1'b0, 32'hFFFF_8001, 32'h0};
        vecs[4]  = '{1'b0, SZ_HALF, 1'b0, 32'h0800_0006, 32'h0,         32'h7FFF_8001, 1,  1'b0, 32'h0000_8001, 32'h0};
        vecs[5]  = '{1'b1, SZ_BYTE, 1'b0, STDOUT_ADDR,   32'h0000_0041, 32'h0,         0,  1'b0, 32'h0,         32'h0000_0041};
        vecs[6]  = '{1'b1, SZ_HALF, 1'b0, 32'h0800_0002, 32'hCAFE_1234, 32'h0,         2,  1'b0, 32'h0,         32'h0000_1234};
        vecs[7]  = '{1'b1, SZ_WORD, 1'b0, EXIT_ADDR,     32'h1234_5678, 32'h0,         0,  1'b0, 32'h0,         32'h1234_5678};
        vecs[8]  = '{1'b0, SZ_WORD, 1'b0, 32'h0800_0002, 32'h0,         32'h0,         0,  1'b1, 32'h0,         32'h0};
        vecs[9]  = '{1'b0, SZ_ILL,  1'b0, 32'h0800_0000, 32'h0,         32'h0,         0,  1'b1, 32'h0,         32'h0};
        vecs[10] = '{1'b0, SZ_HALF, 1'b0, 32'h0800_0001, 32'h0,         32'h0,         0,  1'b1, 32'h0,         32'h0};
        vecs[11] = '{1'b0, SZ_BYTE, 1'b1, 32'h0800_000D, 32'h0,         32'h5555_557F, 3,  1'b0, 32'h0000_007F, 32'h0};
        vecs[12] = '{1'b0, SZ_WORD, 1'b0, 32'h0800_0020, 32'h0,         32'h0,         -1, 1'b1, 32'h0,         32'h0};
        vecs[13] = '{1'b1, SZ_WORD, 1'b0, 32'h0800_0001, 32'h8765_4321, 32'h0,         0,  1'b1, 32'h0,         32'h0};
        vecs[14] = '{1'b0, SZ_WORD, 1'b0, 32'h0800_0100, 32'h0,         32'h0BAD_F00D, 0,  1'b0, 32'h0BAD_F00D, 32'h0};
        vpost    = '{1'b0, SZ_BYTE, 1'b0, 32'h0800_0011, 32'h0,         32'hFFFF_FF9C, 1,  1'b0, 32'h0000_009C, 32'h0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(negedge clk);
        chk("rst MREQ", {31'b0, mreq}, 32'd0);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst rdata", resp_rdata, 32'h0);
        chk("rst DAD", dad, 32'h0);
        chk("rst WRITE", {31'b0, write_o}, 32'd0);
        chk("rst SIZE", {30'b0, size_o}, 32'd0);
        chk_rel("rst DDT", ddt);

        // Table runs back-to-back: each request is presented in the previous resp_valid cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i], $sformatf("vec%0d", i));
            complete(vecs[i], $sformatf("vec%0d", i));
        end

        stale_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("stale%0d resp_valid", i), {31'b0, resp_valid}, 32'd0);
            chk($sformatf("stale%0d hold rdata", i), resp_rdata, 32'h0BAD_F00D);
        end
        stale_ack = 1'b0;
        @(negedge clk);

        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = SZ_WORD;
        req_addr  = 32'h0800_0020;
        req_wdata = 32'hA5A5_A5A5;
        mem_dly   = -1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid MREQ", {31'b0, mreq}, 32'd1);
        chk("mid DDT", ddt, 32'hA5A5_A5A5);
        rst_n = 1'b0;
        #1;
        chk("abort MREQ", {31'b0, mreq}, 32'd0);
        chk_rel("abort DDT", ddt);
        chk("abort DAD", dad, 32'h0);
        chk("abort rdata", resp_rdata, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("abort%0d resp_valid", i), {31'b0, resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        issue(vpost, "post_rst");
        complete(vpost, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_master.md
DMEM_BUS_MASTER -- requirements
Module: dmem_bus_master

Interface
REQ-001 The parameter list SHALL be: BIT_WIDTH, 32, bus data/address width.
REQ-002 The parameter list SHALL be: TIMEOUT, 255, maximum BUS-state cycles before abort (1..255).
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock, rising edge
 rst  in  1  asynchronous active-low reset
 req_valid  in  1  pipeline load/store request
 req_write  in  1  1=store, 0=load
 req_size  in  2  00 word, 01 half, 10 byte (11 illegal)
 req_signed  in  1  sign-extend load result
 req_addr  in  32  byte address
 req_wdata  in  32  store data, right-justified
 req_ready  out  1  request accepted when req_valid&req_ready
 resp_valid  out  1  one-cycle completion pulse
 resp_rdata  out  32  extended load data (0 for stores/errors)
 resp_err  out  1  misaligned, illegal size or timeout; qualified by resp_valid
 DAD  out  32  data bus address
 MREQ  out  1  bus request, active-high
 WRITE  out  1  1=store cycle
 SIZE  out  2  bus size code, same encoding as req_size
 DDT  inout  32  bidirectional data bus
 ACKD_n  in  1  memory acknowledge, active-low

Function
REQ-005 The FSM SHALL have states IDLE and BUS; req_ready SHALL equal (state==IDLE).
REQ-006 On acceptance of an aligned legal request, the block SHALL register DAD, WRITE, SIZE and the write data, assert MREQ and enter BUS at the same edge.
REQ-007 Alignment rules: word needs addr[1:0]==0; half needs addr[0]==0; byte is always aligned; size 11 is illegal.
REQ-008 A misaligned or illegal request SHALL NOT assert MREQ; resp_valid=1 and resp_err=1 SHALL follow for one cycle after the accepting edge, and state SHALL remain IDLE.
REQ-009 ACKD_n SHALL be sampled only at edges where state==BUS; a low level at other times (stale acknowledge) SHALL be ignored.
REQ-010 When ACKD_n==0 is sampled in BUS, the block SHALL deassert MREQ, return to IDLE and pulse resp_valid for one cycle with resp_err=0.
REQ-011 The minimum request-to-resp_valid latency SHALL be 2 edges: accept at edge 0, ack sampled at edge 1, resp_valid high during the cycle after edge 1.
REQ-012 A load SHALL capture DDT at the acknowledging edge: word passes through; half uses DDT[15:0]; byte uses DDT[7:0]; the result is zero-extended, or sign-extended when req_signed (latched at accept).
REQ-013 A store SHALL drive DDT only while state==BUS and WRITE==1: word drives full data; half drives {16'b0,wdata[15:0]}; byte drives {24'b0,wdata[7:0]}. Otherwise DDT SHALL be high-Z.
REQ-014 A cycle counter SHALL clear on entry to BUS; if TIMEOUT cycles elapse without an acknowledge, the block SHALL drop MREQ, release DDT, return to IDLE and pulse resp_valid with resp_err=1.
REQ-015 An acknowledge sampled at the same edge as the timeout SHALL take priority, giving normal completion.
REQ-016 Back-to-back operation: a request presented during a resp_valid cycle SHALL be accepted, so MREQ may be high on consecutive transactions.
REQ-017 resp_rdata SHALL hold its value until the next resp_valid.

Reset
REQ-018 While rst==0, the block SHALL force state=IDLE, MREQ=0, WRITE=0, SIZE=00, DAD=0, resp_valid=0, resp_err=0, resp_rdata=0, counter=0 and DDT=high-Z, asynchronously.
REQ-019 Reset mid-transaction SHALL abort the transaction with no resp_valid; the first acceptance SHALL be possible at the first edge after rst rises.

Structure
REQ-020 A shared include SHALL hold the SIZE encodings (SZ_WORD=00, SZ_HALF=01, SZ_BYTE=10), the state encodings, STDOUT_ADDR=f0000000 and EXIT_ADDR=ff000000.
REQ-021 Lane formatting and extension SHALL be a combinational sub-module, dmem_lane_fmt, shared by the load and store paths.

Verification
REQ-022 Word load at 08000010 with memory acking after 1 cycle, DDT=DEADBEEF -> MREQ high 1 cycle, SIZE=00, resp_rdata=DEADBEEF, resp_err=0, latency 2 edges.
REQ-023 Signed byte load at 08000003 with DDT[7:0]=80 -> resp_rdata=FFFFFF80; unsigned -> 00000080; signed half with DDT[15:0]=8001 -> FFFF8001.
REQ-024 Byte store to F0000000 with wdata=00000041 -> WRITE=1, SIZE=10, DDT=00000041 while MREQ is high, DDT=Z after the ack.
REQ-025 Word load at 08000002 -> no MREQ, resp_valid+resp_err after 1 edge; size 11 -> same behaviour.
REQ-026 ACKD_n held high with TIMEOUT=4 -> MREQ high for exactly 4 cycles, then resp_err=1; ACKD_n held low while IDLE -> no spurious resp_valid.
REQ-027 rst pulled low during BUS -> MREQ=0 and DDT=Z immediately, no resp_valid; a new request after release completes normally.
